dmem_bus_ctrl: RTL
==================

# dmem_bus_ctrl

Data-memory bus controller sitting directly downstream of the load/store unit. It takes the LSU's word address, masked store data and 32-bit store mask, runs one transaction on the core's valid/ready data bus, and stalls the pipeline until the bus completes. It returns registered read data to the LSU's read-data input for load extension. A timeout counter aborts transactions that get no response.

## Interface
- TIMEOUT, 255: maximum cycles `bus_valid` may stay high without `bus_ready`; legal range 1..65535.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_rd  in  1  load request from decode/control, held until stall falls
- req_wr  in  1  store request, held until stall falls
- addr  in  32  LSU data address
- wr_data  in  32  LSU store data, already masked
- wr_mask  in  32  LSU store mask, one bit per data bit
- rd_data  out  32  registered read data to LSU
- stall  out  1  pipeline hold
- mem_err  out  1  one-cycle error pulse on completion
- bus_valid  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address `{addr[31:2],2'b00}`
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables
- bus_ready  in  1  slave accept/complete
- bus_rdata  in  32  slave read data, valid with `bus_ready`
- bus_err  in  1  slave error, valid with `bus_ready`

## Operation
- FSM with states IDLE, BUS and DONE; reset state is IDLE.
- **IDLE**:
  - If `req_wr` is high, latch a write. `req_wr` wins when both requests are high.
  - Else if `req_rd` is high, latch a read.
  - Latch `bus_addr`, `bus_we`, `bus_wdata` and `bus_be`, then go to BUS.
  - A write with `wr_mask == 0` skips the bus and goes straight to DONE without error.
- **Byte enables**: for a write, `bus_be[i] = |wr_mask[8i+7:8i]`. For a read, `bus_be = 4'b1111`.
- **BUS**:
  - `bus_valid` is high. `bus_addr`, `bus_we`, `bus_wdata` and `bus_be` are registered and stable for the whole state.
  - A 16-bit counter `tcnt` clears on entry and increments each cycle without `bus_ready`.
  - On `bus_ready`: a read loads `rd_data <= bus_rdata`. If `bus_err` is high, load `rd_data <= 0` and flag an error. Go to DONE.
  - If `tcnt == TIMEOUT-1` and `bus_ready` is low: abort, flag an error, load `rd_data <= 0` for a read, go to DONE.
- **DONE**:
  - Lasts one cycle. `stall` is 0 and `mem_err` reflects the flagged error. Go to IDLE.
  - Requests seen in DONE are ignored; they belong to the instruction that just completed.
- `stall = (state==BUS) | (state==IDLE & (req_rd|req_wr))`. This is combinational from the inputs.
- `rd_data` holds its value until the next read completes. Writes never change it.
- Only one transaction is outstanding at a time; there is no pipelining.

## Timing
- Reset values: state IDLE; `rd_data` 0; `bus_valid`, `bus_we` and `mem_err` 0; `bus_addr` and `bus_wdata` 0; `bus_be` 0; `tcnt` 0.
- When `rst_n` asserts mid-transaction, `bus_valid` drops asynchronously and the transaction is lost.
- Request seen in cycle 0 (IDLE):
  - `bus_valid` is high from cycle 1.
  - If `bus_ready` is high in cycle 1, DONE is cycle 2.
  - `stall` is high in cycles 0–1 and low in cycle 2.
  - `rd_data` is valid from cycle 2.
- With N wait cycles, `stall` is high for N+2 cycles.
- Timeout: `bus_valid` is high for exactly TIMEOUT cycles, then DONE with `mem_err = 1`.
- `bus_ready` arriving in the same cycle as the timeout compare counts as success, not error.
- A zero-mask write: request in cycle 0, DONE in cycle 1, `bus_valid` never rises.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. Minimum period is 3 cycles per access.

## Test plan
- **Read, zero wait**:
  - Stimulus: `req_rd=1`, `addr=0x1006`; slave returns `ready=1`, `rdata=0xDEADBEEF` on the first valid cycle.
  - Required: `bus_addr=0x1004`, `bus_be=4'hF`, `stall` high for 2 cycles, `rd_data=0xDEADBEEF` in DONE, `mem_err=0`.
- **Halfword store**:
  - Stimulus: `req_wr=1`, `wr_mask=0x0000FFFF`, `wr_data=0x00001234`, slave with 3 wait cycles.
  - Required: `bus_be=4'b0011`, `bus_we=1`, bus fields stable for 4 valid cycles, `stall` high for 5 cycles, `rd_data` unchanged.
- **Timeout**:
  - Stimulus: TIMEOUT=4, `req_rd`, slave never ready.
  - Required: `bus_valid` high exactly 4 cycles, `mem_err` pulses 1 cycle, `rd_data=0`.
- **Slave error, then zero-mask write**:
  - Stimulus: read completes with `bus_err=1`; next, `req_wr` with `wr_mask=0`.
  - Required: `mem_err` pulse and `rd_data=0` for the read; no `bus_valid` for the write, `stall` high for 1 cycle.
- **Simultaneous requests**:
  - Stimulus: `req_rd=1` and `req_wr=1`.
  - Required: a write is issued.
- **Reset mid-transaction**:
  - Stimulus: assert `rst_n` while in BUS.
  - Required: `bus_valid` low immediately, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: runs one LSU load/store on the valid/ready data bus,
// holds the pipeline until completion, and aborts slaves that never answer.
//
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   req_rd, req_wr        load / store request, held until stall falls
//   addr, wr_data,        LSU address, masked store data and
//   wr_mask               per-bit store mask
//   rd_data               registered load data (last completed read)
//   stall                 pipeline hold
//   mem_err               one-cycle error pulse in the completion cycle
//   bus_valid, bus_we,    bus request, direction,
//   bus_addr, bus_wdata,  word-aligned address, write data
//   bus_be                byte enables
//   bus_ready, bus_rdata, slave accept, read data and error,
//   bus_err               all qualified by bus_ready
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] wr_mask,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        mem_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tcnt;
  logic [3:0]  be_w;
  logic        req;
  logic        skip;

  always_comb begin
    be_w = '0;
    for (int i = 0; i < 4; i++) begin
      be_w[i] = |wr_mask[8*i +: 8];
    end
  end

  assign req  = req_rd | req_wr;
  // A store that touches no byte has nothing to put on the bus.
  assign skip = req_wr & (wr_mask == '0);

  assign stall = (state == BUS) |
                 ((state == IDLE) & req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      rd_data   <= '0;
      mem_err   <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_err <= 1'b0;
          if (req) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= req_wr;
            bus_wdata <= wr_data;
            bus_be    <= req_wr ? be_w : 4'hF;
            tcnt      <= '0;
            if (skip) begin
              state <= DONE;
            end else begin
              bus_valid <= 1'b1;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          // A response on the last allowed cycle still wins
          // over the timeout.
          if (bus_ready) begin
            bus_valid <= 1'b0;
            mem_err   <= bus_err;
            state     <= DONE;
            if (!bus_we) begin
              rd_data <= bus_err ? '0 : bus_rdata;
            end
          end else if (tcnt == TLIM) begin
            bus_valid <= 1'b0;
            mem_err   <= 1'b1;
            state     <= DONE;
            if (!bus_we) begin
              rd_data <= '0;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DONE: begin
          // Requests still high here belong to the access
          // that just finished.
          mem_err <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
